// File: rtl/first_pass_labeler_pkg.sv
// -----------------------------------------------------------------------------
// first_pass_labeler_pkg
// Shared constants and types for the first raster pass of connected-component
// labelling: frame geometry, label/address widths, FSM state encodings and a
// small helper for picking the smaller of two labels.
// -----------------------------------------------------------------------------
package first_pass_labeler_pkg;

    localparam int FRAME_W = 320;   // pixels per line
    localparam int FRAME_H = 240;   // lines per frame
    localparam int LBL_W   = 6;     // provisional label width
    localparam int ADDR_W  = 17;    // label RAM address width (>= FRAME_W*FRAME_H-1)

    typedef logic [LBL_W-1:0]  label_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam label_t LBL_BG  = '0;   // background label
    localparam label_t LBL_MAX = '1;   // last usable label (63)

    // FSM encodings kept as plain constants so the state register stays a
    // simple vector.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Outcome of the neighbour comparison for one pixel.
    typedef struct packed {
        label_t lbl;        // label assigned to the pixel
        logic   new_label;  // pixel needs a fresh label
        logic   conflict;   // up and left are both set but differ
    } label_dec_t;

    function automatic label_t min_label(input label_t a, input label_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/first_pass_labeler_if.sv
// -----------------------------------------------------------------------------
// first_pass_labeler_if
// Pixel input stream, label RAM write port, equivalence-pair output and frame
// status of the first-pass labeler.
//   master : pixel source / downstream consumer side (drives iSOF/iDVAL/iSKIN)
//   slave  : the labeler itself (drives the write port, pair and status)
// -----------------------------------------------------------------------------
interface first_pass_labeler_if;
    import first_pass_labeler_pkg::*;

    logic   iSOF;              // start-of-frame pulse
    logic   iDVAL;             // pixel valid
    logic   iSKIN;             // mask pixel, 1 = foreground
    logic   owr_en;            // label RAM write strobe
    addr_t  owr_addr;          // label RAM address = y*WIDTH+x
    label_t owr_data;          // label written
    label_t olabel_1;          // equivalence pair: up label
    label_t olabel_2;          // equivalence pair: left label
    logic   oResolve;          // pair valid strobe
    logic   olabeling_finish;  // frame pass complete (level)
    logic   oOverflow;         // label space exhausted (sticky per frame)

    modport master (
        output iSOF, iDVAL, iSKIN,
        input  owr_en, owr_addr, owr_data, olabel_1, olabel_2,
        input  oResolve, olabeling_finish, oOverflow
    );

    modport slave (
        input  iSOF, iDVAL, iSKIN,
        output owr_en, owr_addr, owr_data, olabel_1, olabel_2,
        output oResolve, olabeling_finish, oOverflow
    );

endinterface

// File: rtl/first_pass_labeler_line_buffer.sv
// -----------------------------------------------------------------------------
// label_line_buffer
// One line of provisional labels (DEPTH x LBL_W). Read is combinational at
// addr so the up-neighbour is available in the same cycle the pixel arrives;
// the new label is written back to the same column at the clock edge.
// No clear is required: the consumer ignores the read value on row 0.
//   clk   : clock
//   we    : write enable
//   addr  : column (read and write)
//   wdata : label to store
//   rdata : label currently stored at addr (previous line)
// -----------------------------------------------------------------------------
module label_line_buffer
    import first_pass_labeler_pkg::*;
#(
    parameter int DEPTH = FRAME_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  label_t        wdata,
    output label_t        rdata
);

    label_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/first_pass_labeler.sv
// -----------------------------------------------------------------------------
// first_pass_labeler
// First raster pass of 4-connected component labelling on a binary mask.
// Each accepted pixel receives a provisional label from its up/left
// neighbours (or a fresh one), the label is written to the frame label RAM,
// and a conflicting up/left pair is reported as an equivalence. All outputs
// appear one cycle after the pixel is accepted.
//   iclk    : clock
//   irst_n  : asynchronous active-low reset
//   bus     : slave side of first_pass_labeler_if (pixel stream in; label
//             RAM write port, equivalence pair, finish and overflow out)
// -----------------------------------------------------------------------------
module first_pass_labeler
    import first_pass_labeler_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int HEIGHT = FRAME_H
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    first_pass_labeler_if.slave  bus
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    // next_label carries one extra bit: reaching 2**LBL_W means every
    // label including LBL_MAX has been handed out.
    localparam logic [LBL_W:0] NL_FIRST = (LBL_W+1)'(1);

    logic [1:0]     state_reg;
    logic [XW-1:0]  x_reg;
    logic [YW-1:0]  y_reg;
    label_t         left_reg;
    logic [LBL_W:0] next_label_reg;
    addr_t          addr_reg;
    logic           overflow_reg;
    logic           finish_reg;
    logic           wr_en_reg;
    addr_t          wr_addr_reg;
    label_t         wr_data_reg;
    logic           resolve_reg;
    label_t         label_1_reg;
    label_t         label_2_reg;

    // iSOF restarts the pass in the same cycle, so the pixel presented with
    // it is treated as (0,0) of a fresh frame.
    logic           sof;
    logic           accept;
    logic [XW-1:0]  x_cur;
    logic [YW-1:0]  y_cur;
    label_t         left_cur;
    logic [LBL_W:0] next_cur;
    addr_t          addr_cur;
    logic           exhausted;
    label_t         up_rd;
    label_t         up;
    label_dec_t     dec;

    assign sof       = bus.iSOF;
    assign accept    = bus.iDVAL && (sof || (state_reg == ST_SCAN));
    assign x_cur     = sof ? '0 : x_reg;
    assign y_cur     = sof ? '0 : y_reg;
    assign left_cur  = sof ? LBL_BG : left_reg;
    assign next_cur  = sof ? NL_FIRST : next_label_reg;
    assign addr_cur  = sof ? '0 : addr_reg;
    assign exhausted = next_cur[LBL_W];

    label_line_buffer #(.DEPTH(WIDTH)) u_line_buf (
        .clk   (iclk),
        .we    (accept),
        .addr  (x_cur),
        .wdata (dec.lbl),
        .rdata (up_rd)
    );

    // Row 0 has no line above; the buffer still holds the previous frame.
    assign up = (y_cur == '0) ? LBL_BG : up_rd;

    always_comb begin
        dec.lbl       = LBL_BG;
        dec.new_label = 1'b0;
        dec.conflict  = 1'b0;
        if (bus.iSKIN) begin
            if (up == LBL_BG && left_cur == LBL_BG) begin
                dec.new_label = 1'b1;
                dec.lbl       = exhausted ? LBL_MAX : next_cur[LBL_W-1:0];
            end else if (up == LBL_BG) begin
                dec.lbl = left_cur;
            end else if (left_cur == LBL_BG) begin
                dec.lbl = up;
            end else if (up == left_cur) begin
                dec.lbl = up;
            end else begin
                dec.lbl      = min_label(up, left_cur);
                dec.conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_reg      <= ST_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            left_reg       <= LBL_BG;
            next_label_reg <= NL_FIRST;
            addr_reg       <= '0;
            overflow_reg   <= 1'b0;
            finish_reg     <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= LBL_BG;
            resolve_reg    <= 1'b0;
            label_1_reg    <= LBL_BG;
            label_2_reg    <= LBL_BG;
        end else begin
            wr_en_reg   <= accept;
            resolve_reg <= accept && dec.conflict;
            if (accept) begin
                wr_addr_reg <= addr_cur;
                wr_data_reg <= dec.lbl;
            end
            if (accept && dec.conflict) begin
                label_1_reg <= up;
                label_2_reg <= left_cur;
            end

            if (sof) begin
                state_reg      <= ST_SCAN;
                x_reg          <= '0;
                y_reg          <= '0;
                left_reg       <= LBL_BG;
                next_label_reg <= NL_FIRST;
                addr_reg       <= '0;
                overflow_reg   <= 1'b0;
                finish_reg     <= 1'b0;
            end

            // Pixel advance overrides the restart values above when a
            // pixel arrives together with iSOF.
            if (accept) begin
                addr_reg <= addr_cur + 1'b1;
                if (x_cur == X_LAST) begin
                    x_reg    <= '0;
                    left_reg <= LBL_BG;
                    if (y_cur == Y_LAST) begin
                        y_reg      <= '0;
                        state_reg  <= ST_DONE;
                        finish_reg <= 1'b1;
                    end else begin
                        y_reg <= y_cur + 1'b1;
                    end
                end else begin
                    x_reg    <= x_cur + 1'b1;
                    left_reg <= dec.lbl;
                end
                if (dec.new_label) begin
                    if (exhausted) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        next_label_reg <= next_cur + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.owr_en           = wr_en_reg;
    assign bus.owr_addr         = wr_addr_reg;
    assign bus.owr_data         = wr_data_reg;
    assign bus.olabel_1         = label_1_reg;
    assign bus.olabel_2         = label_2_reg;
    assign bus.oResolve         = resolve_reg;
    assign bus.olabeling_finish = finish_reg;
    assign bus.oOverflow        = overflow_reg;

endmodule

// File: tb/tb_first_pass_labeler.sv
// -----------------------------------------------------------------------------
// tb_first_pass_labeler
// Directed testbench for first_pass_labeler. Each pix() call presents one
// cycle of inputs and returns 1 time unit after the following clock edge,
// where the registered outputs for that cycle are visible.
// -----------------------------------------------------------------------------
module tb_first_pass_labeler;

    logic iclk;
    logic irst_n;
    int   checks = 0;
    int   errors = 0;

    first_pass_labeler_if bus ();

    first_pass_labeler dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic sof, input logic dval, input logic skin);
        bus.iSOF  = sof;
        bus.iDVAL = dval;
        bus.iSKIN = skin;
        @(posedge iclk);
        #1;
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iSKIN = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},  32'(bus.owr_en), 32'd0);
        check({tag, "_addr"},   32'(bus.owr_addr), 32'd0);
        check({tag, "_data"},   32'(bus.owr_data), 32'd0);
        check({tag, "_lbl1"},   32'(bus.olabel_1), 32'd0);
        check({tag, "_lbl2"},   32'(bus.olabel_2), 32'd0);
        check({tag, "_res"},    32'(bus.oResolve), 32'd0);
        check({tag, "_finish"}, 32'(bus.olabeling_finish), 32'd0);
        check({tag, "_ovf"},    32'(bus.oOverflow), 32'd0);
    endtask

    // Watchdog: the directed sequence is finite, this only guards a hang.
    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       res_seen;
        int         writes;
        int         extra_writes;
        int         last_addr;
        logic       finish_early;
        logic       skin;

        irst_n    = 1'b0;
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iSKIN = 1'b0;
        repeat (3) @(posedge iclk);
        #1;

        // ---- reset state ----
        $display("step: reset state");
        check_all_zero("reset");
        irst_n = 1'b1;

        // pixel in IDLE is ignored
        pix(1'b0, 1'b1, 1'b1);
        check("idle_ignore_wr_en", 32'(bus.owr_en), 32'd0);

        // ---- test 1: reset mid-stream ----
        $display("step: reset mid-stream");
        pix(1'b1, 1'b1, 1'b1);
        check("t1_first_wr_en", 32'(bus.owr_en), 32'd1);
        check("t1_first_data",  32'(bus.owr_data), 32'd1);
        pix(1'b0, 1'b1, 1'b1);
        check("t1_second_addr", 32'(bus.owr_addr), 32'd1);
        check("t1_second_data", 32'(bus.owr_data), 32'd1);
        irst_n = 1'b0;
        #1;
        check_all_zero("t1_midreset");
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        pix(1'b0, 1'b1, 1'b1);
        check("t1_post_reset_idle_wr_en", 32'(bus.owr_en), 32'd0);
        pix(1'b1, 1'b1, 1'b1);
        check("t1_after_sof_wr_en", 32'(bus.owr_en), 32'd1);
        check("t1_after_sof_addr",  32'(bus.owr_addr), 32'd0);
        check("t1_after_sof_data",  32'(bus.owr_data), 32'd1);

        // ---- test 2: single pixel at (5,0) ----
        $display("step: single pixel");
        pix(1'b1, 1'b0, 1'b0);
        res_seen = 1'b0;
        for (int x = 0; x <= 5; x++) begin
            pix(1'b0, 1'b1, (x == 5));
            res_seen = res_seen | bus.oResolve;
        end
        check("t2_wr_en", 32'(bus.owr_en), 32'd1);
        check("t2_addr",  32'(bus.owr_addr), 32'd5);
        check("t2_data",  32'(bus.owr_data), 32'd1);
        check("t2_no_resolve", 32'(res_seen), 32'd0);

        // ---- test 3: two bars merged by a bridge ----
        $display("step: bars and bridge");
        pix(1'b1, 1'b0, 1'b0);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 320; x++) begin
                skin = (y < 2) ? (x == 2 || x == 4) : (x >= 2 && x <= 4);
                pix(1'b0, 1'b1, skin);
                if (y == 0 && x == 2) check("t3_bar_a", 32'(bus.owr_data), 32'd1);
                if (y == 0 && x == 4) check("t3_bar_b", 32'(bus.owr_data), 32'd2);
                if (y == 1 && x == 4) check("t3_bar_b_row1", 32'(bus.owr_data), 32'd2);
                if (y == 2 && x == 3) begin
                    check("t3_bridge_mid", 32'(bus.owr_data), 32'd1);
                    check("t3_bridge_mid_res", 32'(bus.oResolve), 32'd0);
                end
                if (y == 2 && x == 4) begin
                    check("t3_res",  32'(bus.oResolve), 32'd1);
                    check("t3_lbl1", 32'(bus.olabel_1), 32'd2);
                    check("t3_lbl2", 32'(bus.olabel_2), 32'd1);
                    check("t3_data", 32'(bus.owr_data), 32'd1);
                    check("t3_addr", 32'(bus.owr_addr), 32'd644);
                end
                if (y == 2 && x == 5) check("t3_res_drop", 32'(bus.oResolve), 32'd0);
            end
        end

        // ---- test 4: label exhaustion ----
        $display("step: label overflow");
        pix(1'b1, 1'b0, 1'b0);
        for (int x = 0; x < 128; x++) begin
            pix(1'b0, 1'b1, (x % 2 == 0));
            if (x == 0)   check("t4_first_lbl", 32'(bus.owr_data), 32'd1);
            if (x == 60)  check("t4_lbl31", 32'(bus.owr_data), 32'd31);
            if (x == 124) begin
                check("t4_lbl63", 32'(bus.owr_data), 32'd63);
                check("t4_ovf_before", 32'(bus.oOverflow), 32'd0);
            end
            if (x == 126) begin
                check("t4_lbl64th", 32'(bus.owr_data), 32'd63);
                check("t4_ovf", 32'(bus.oOverflow), 32'd1);
            end
        end
        check("t4_ovf_sticky", 32'(bus.oOverflow), 32'd1);
        pix(1'b1, 1'b0, 1'b0);
        check("t4_ovf_clear", 32'(bus.oOverflow), 32'd0);

        // ---- test 6: iSOF mid-frame at (100,50) ----
        $display("step: restart mid-frame");
        pix(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 50*320 + 100; n++) begin
            pix(1'b0, 1'b1, 1'b0);
        end
        check("t6_pre_addr", 32'(bus.owr_addr), 32'd16099);
        pix(1'b1, 1'b1, 1'b1);
        check("t6_wr_en",  32'(bus.owr_en), 32'd1);
        check("t6_addr",   32'(bus.owr_addr), 32'd0);
        check("t6_data",   32'(bus.owr_data), 32'd1);
        check("t6_finish", 32'(bus.olabeling_finish), 32'd0);
        pix(1'b0, 1'b1, 1'b0);
        check("t6_next_addr", 32'(bus.owr_addr), 32'd1);

        // ---- test 5: full frame with gapped iDVAL ----
        $display("step: full frame");
        pix(1'b1, 1'b0, 1'b0);
        writes       = 0;
        last_addr    = 0;
        finish_early = 1'b0;
        for (int n = 0; n < 76800; n++) begin
            if (n % 1024 == 1000) begin
                pix(1'b0, 1'b0, 1'b0);
                if (bus.owr_en) writes++;
            end
            pix(1'b0, 1'b1, (n % 7 == 0));
            if (bus.owr_en) begin
                writes++;
                last_addr = int'(bus.owr_addr);
            end
            if (n < 76799 && bus.olabeling_finish) finish_early = 1'b1;
        end
        check("t5_writes",       32'(writes), 32'd76800);
        check("t5_last_addr",    32'(last_addr), 32'd76799);
        check("t5_finish",       32'(bus.olabeling_finish), 32'd1);
        check("t5_finish_early", 32'(finish_early), 32'd0);
        extra_writes = 0;
        for (int n = 0; n < 5; n++) begin
            pix(1'b0, 1'b1, 1'b1);
            if (bus.owr_en) extra_writes++;
        end
        check("t5_extra_writes", 32'(extra_writes), 32'd0);
        check("t5_finish_held",  32'(bus.olabeling_finish), 32'd1);
        pix(1'b1, 1'b0, 1'b0);
        check("t5_finish_clear", 32'(bus.olabeling_finish), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
